tx_sequence_modulator: RTL and testbench
========================================

Name: tx_sequence_modulator

Overview:
- Transmit-side counterpart of the RX correlator chain. Generates the BPSK-modulated ultrasonic burst for one of 16 PN sequences, which the RX chain correlates against.
- Emits one signed 16-bit carrier sample per sample-rate strobe, toward the DAC path.
- Frames the burst with a start/busy/done handshake.
- The chip sequence comes from an 8-bit maximal-length LFSR. The per-sequence seed comes from a shared table.

Parameters:
- CHIP_COUNT, 255, chips per burst (one full LFSR period).
- CYCLES_PER_CHIP, 2, carrier periods per chip.
- CARRIER_LEN, 8, samples per carrier period (length of the sine LUT).

Ports:
- ctx_clk  in  1  clock
- rtx_rst  in  1  asynchronous reset, active-low
- etx_en  in  1  enable; low freezes all state
- isample_tick  in  1  sample-rate strobe, one cycle wide
- istart  in  1  start request, sampled only in IDLE
- istop  in  1  abort; returns the block to IDLE
- iseq_sel  in  4  sequence index 0..15, latched at start
- iamp_shift  in  2  arithmetic right shift applied to each sample, latched at start
- osample  out  16 signed  modulated sample
- osample_valid  out  1  one-cycle pulse when osample updates
- obusy  out  1  high from LOAD through RUN
- odone  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset (rtx_rst low, async): state=IDLE; osample=0; osample_valid=0; obusy=0; odone=0; all counters 0; LFSR=0.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE -> LOAD when istart && etx_en. Latch iseq_sel and iamp_shift; obusy goes high in the next cycle.
  - LOAD (1 cycle): LFSR <= SEED[seq]; phase=0; cyc=0; chip=0. Go to RUN.
  - RUN: on each isample_tick, register the output sample (latency 1 cycle from tick to osample/osample_valid), then advance:
    - phase++ modulo CARRIER_LEN.
    - On phase wrap: cyc++.
    - On cyc wrap (CYCLES_PER_CHIP): step the LFSR and chip++.
    - When the tick that outputs the last sample of chip CHIP_COUNT-1 occurs, go to DONE.
  - DONE (1 cycle): odone=1; obusy=0 in the next cycle; osample=0. Go to IDLE.
- Sample value: s = LUT[phase] if lfsr[0]==1, else -LUT[phase]; then osample = s >>> amp_shift.
- LUT is symmetric with |max|=32767, so negation never overflows.
- LFSR: Fibonacci, x^8+x^6+x^5+x^4+1. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Period is 255; all seeds are nonzero.
- osample holds its value between ticks. Outside RUN, osample is 0.
- Burst length: CHIP_COUNT*CYCLES_PER_CHIP*CARRIER_LEN ticks (4080 by default).
- Boundary and simultaneous-event rules:
  - istart while obusy: ignored.
  - istart and isample_tick in the same IDLE cycle: the tick is ignored; the first sample comes on the first tick seen in RUN.
  - A tick during LOAD is ignored.
  - istop in any state: next state IDLE; osample=0, osample_valid=0, obusy=0 next cycle; no odone. istop has priority over istart and over ticks.
  - etx_en low: state, counters, LFSR and outputs hold; ticks are ignored; osample_valid=0; odone is not emitted while disabled. istop and reset still act while disabled.
  - Reset mid-burst: immediate return to reset values; no odone.
  - Back-to-back bursts: istart may be asserted in the cycle after DONE (IDLE).

Decomposition:
- Shared package tx_pkg:
  - SINE_LUT[8] = 0, 23170, 32767, 23170, 0, -23170, -32767, -23170.
  - SEED[16]: nonzero 8-bit seeds; SEED[0]=8'h01, SEED[1]=8'h5A, the rest distinct.
  - The LFSR tap constant.
  - State encoding localparams.
  - The RX correlator reference sequences are derived from the same SEED table.
- Sub-module tx_lfsr: 8-bit LFSR with load, step and enable; output bit [0].

Test Plan:
- Reset, then seq 0, shift 0, ticks every 4 cycles.
  - Expect obusy high 1 cycle after istart.
  - First 4 samples: 0, 23170, 32767, 23170. SEED=8'h01 gives chip 1, so all positive.
  - Each sample appears 1 cycle after its tick, with a single osample_valid pulse.
- Full burst, seq 0: count 4080 osample_valid pulses.
  - odone pulses exactly once, 1 cycle after the last sample's cycle.
  - obusy falls with odone.
  - The chip sign sequence matches a software LFSR seeded 8'h01 for all 255 chips.
- iamp_shift=2, seq 0: first samples 0, 5792, 8191, 5792. A negative chip sample of -23170 gives -5793 (arithmetic floor).
- istop at tick 100: osample=0, obusy=0 next cycle, no odone. A new istart then restarts at phase 0 with a fresh seed.
- etx_en low for 50 cycles mid-burst with ticks present: no osample_valid pulses, osample held. After re-enable, the sample sequence continues with no skipped phase; the total is still 4080.
- Async reset asserted mid-burst, off the clock edge: all outputs go to 0 immediately. istart during busy and istart+tick in IDLE follow the ignore rules (first sample on the next tick in RUN).

Source files
------------

// File: rtl/tx_pkg.sv
// Shared TX/RX constants: carrier sine table, per-sequence LFSR seeds, LFSR taps, FSM encoding.
// The RX correlator reference sequences are generated from the same SEED table.
package tx_pkg;

   localparam int SINE_LEN = 8;
   localparam int SEQ_NUM  = 16;

   localparam logic signed [15:0] SINE_LUT [SINE_LEN] = '{
      16'sd0, 16'sd23170, 16'sd32767, 16'sd23170,
      16'sd0, -16'sd23170, -16'sd32767, -16'sd23170
   };

   // Must stay nonzero: an all-zero LFSR never leaves zero.
   localparam logic [7:0] SEED [SEQ_NUM] = '{
      8'h01, 8'h5A, 8'hA3, 8'h3C, 8'hC5, 8'h7E, 8'hE1, 8'h12,
      8'h9B, 8'h24, 8'hB6, 8'h48, 8'hD9, 8'h6D, 8'hF0, 8'h8F
   };

   // x^8+x^6+x^5+x^4+1 as feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_LOAD_ENC = 2'd1;
   localparam logic [1:0] ST_RUN_ENC  = 2'd2;
   localparam logic [1:0] ST_DONE_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_LOAD = ST_LOAD_ENC,
      ST_RUN  = ST_RUN_ENC,
      ST_DONE = ST_DONE_ENC
   } tx_state_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/tx_lfsr.sv
// 8-bit Fibonacci chip generator; load wins over step, both gated by en. Output is bit 0.
// Single-cycle update, no backpressure.
module tx_lfsr
   import tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       step,
   output logic       chip
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= '0;
      end else if (en) begin
         if (load) begin
            lfsr_q <= seed;
         end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
         end
      end
   end

   assign chip = lfsr_q[0];

endmodule

// File: rtl/tx_sequence_modulator.sv
// BPSK burst generator: one carrier sample per sample tick, sign set by the PN chip, framed by busy/done.
// Sample latency 1 cycle from tick; no backpressure -- the DAC path consumes every osample_valid pulse.
module tx_sequence_modulator
   import tx_pkg::*;
#(
   parameter int CHIP_COUNT      = 255,
   parameter int CYCLES_PER_CHIP = 2,
   parameter int CARRIER_LEN     = 8
) (
   input  logic               ctx_clk,
   input  logic               rtx_rst,
   input  logic               etx_en,
   input  logic               isample_tick,
   input  logic               istart,
   input  logic               istop,
   input  logic [3:0]         iseq_sel,
   input  logic [1:0]         iamp_shift,
   output logic signed [15:0] osample,
   output logic               osample_valid,
   output logic               obusy,
   output logic               odone
);

   localparam int PH_W   = $clog2(CARRIER_LEN);
   localparam int CYC_W  = (CYCLES_PER_CHIP > 1) ? $clog2(CYCLES_PER_CHIP) : 1;
   localparam int CHIP_W = $clog2(CHIP_COUNT);

   localparam logic [PH_W-1:0]   PH_MAX   = PH_W'(CARRIER_LEN - 1);
   localparam logic [CYC_W-1:0]  CYC_MAX  = CYC_W'(CYCLES_PER_CHIP - 1);
   localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(CHIP_COUNT - 1);

   tx_state_t state, state_nxt;

   logic [3:0]        seq_q;
   logic [1:0]        shift_q;
   logic [PH_W-1:0]   phase;
   logic [CYC_W-1:0]  cyc;
   logic [CHIP_W-1:0] chip;
   logic              chip_bit;

   logic              tick_adv;
   logic              phase_wrap;
   logic              chip_wrap;
   logic              burst_end;
   logic              lfsr_load;

   logic signed [15:0] lut_val;
   logic signed [15:0] sample_sgn;
   logic signed [15:0] sample_out;

   // istop outranks every tick, so a stopping cycle never advances the burst.
   assign tick_adv   = etx_en && !istop && (state == ST_RUN) && isample_tick;
   assign phase_wrap = (phase == PH_MAX);
   assign chip_wrap  = phase_wrap && (cyc == CYC_MAX);
   assign burst_end  = tick_adv && chip_wrap && (chip == CHIP_MAX);
   assign lfsr_load  = etx_en && !istop && (state == ST_LOAD);

   assign lut_val    = SINE_LUT[phase];
   assign sample_sgn = chip_bit ? lut_val : -lut_val;
   assign sample_out = sample_sgn >>> shift_q;

   tx_lfsr u_lfsr (
      .clk   (ctx_clk),
      .rst_n (rtx_rst),
      .en    (etx_en),
      .load  (lfsr_load),
      .seed  (SEED[seq_q]),
      .step  (tick_adv && chip_wrap),
      .chip  (chip_bit)
   );

   always_ff @(posedge ctx_clk or negedge rtx_rst) begin
      if (!rtx_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (istop) begin
         state_nxt = ST_IDLE;
      end else if (etx_en) begin
         case (state)
            ST_IDLE: if (istart) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (burst_end) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ctx_clk or negedge rtx_rst) begin
      if (!rtx_rst) begin
         seq_q   <= '0;
         shift_q <= '0;
         phase   <= '0;
         cyc     <= '0;
         chip    <= '0;
      end else if (etx_en && !istop) begin
         if (state == ST_IDLE && istart) begin
            seq_q   <= iseq_sel;
            shift_q <= iamp_shift;
         end
         if (state == ST_LOAD) begin
            phase <= '0;
            cyc   <= '0;
            chip  <= '0;
         end else if (tick_adv) begin
            if (phase_wrap) begin
               phase <= '0;
               if (cyc == CYC_MAX) begin
                  cyc  <= '0;
                  chip <= chip + 1'b1;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end else begin
               phase <= phase + 1'b1;
            end
         end
      end
   end

   // Outputs are registered from the next state so busy rises the cycle after start
   // and falls together with the done pulse.
   always_ff @(posedge ctx_clk or negedge rtx_rst) begin
      if (!rtx_rst) begin
         osample       <= '0;
         osample_valid <= 1'b0;
         obusy         <= 1'b0;
         odone         <= 1'b0;
      end else if (istop) begin
         osample       <= '0;
         osample_valid <= 1'b0;
         obusy         <= 1'b0;
         odone         <= 1'b0;
      end else if (!etx_en) begin
         osample_valid <= 1'b0;
         odone         <= 1'b0;
      end else begin
         obusy         <= (state_nxt != ST_IDLE);
         odone         <= (state == ST_DONE);
         osample_valid <= tick_adv;
         if (tick_adv) begin
            osample <= sample_out;
         end else if (state != ST_RUN) begin
            osample <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tx_sequence_modulator.sv
// Scoreboard bench: expected samples queued as ticks are driven, compared when osample_valid fires.
module tb_tx_sequence_modulator;

   logic               ctx_clk = 1'b0;
   logic               rtx_rst;
   logic               etx_en;
   logic               isample_tick;
   logic               istart;
   logic               istop;
   logic [3:0]         iseq_sel;
   logic [1:0]         iamp_shift;
   logic signed [15:0] osample;
   logic               osample_valid;
   logic               obusy;
   logic               odone;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_q[$];
   int          n_valid  = 0;
   int          n_done   = 0;
   int          m_idx    = 0;
   int          m_shift  = 0;
   int          last_exp = 0;
   logic [7:0]  m_lfsr   = 8'h00;
   int          lut_tab [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

   always #5 ctx_clk = ~ctx_clk;

   tx_sequence_modulator dut (
      .ctx_clk       (ctx_clk),
      .rtx_rst       (rtx_rst),
      .etx_en        (etx_en),
      .isample_tick  (isample_tick),
      .istart        (istart),
      .istop         (istop),
      .iseq_sel      (iseq_sel),
      .iamp_shift    (iamp_shift),
      .osample       (osample),
      .osample_valid (osample_valid),
      .obusy         (obusy),
      .odone         (odone)
   );

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] sw_lfsr(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic int exp_sample(input int idx, input logic [7:0] l, input int sh);
      int v;
      v = lut_tab[idx % 8];
      if (!l[0]) v = -v;
      return v >>> sh;
   endfunction

   always @(negedge ctx_clk) begin
      int e;
      if (osample_valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sample", osample, e);
         end
      end
      if (odone === 1'b1) n_done++;
   end

   task automatic do_tick();
      isample_tick = 1'b1;
      last_exp = exp_sample(m_idx, m_lfsr, m_shift);
      exp_q.push_back(last_exp);
      m_idx++;
      if (m_idx % 16 == 0) m_lfsr = sw_lfsr(m_lfsr);
      @(negedge ctx_clk);
      isample_tick = 1'b0;
      chk("valid_latency", osample_valid, 1);
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         do_tick();
         if (i != n - 1) repeat (gap - 1) @(negedge ctx_clk);
      end
   endtask

   // Start with LOAD-cycle tick and scrambled selectors after the start cycle.
   task automatic start_burst(input logic [3:0] seq, input logic [1:0] sh,
                              input logic [7:0] seed, input logic with_tick);
      iseq_sel     = seq;
      iamp_shift   = sh;
      istart       = 1'b1;
      isample_tick = with_tick;
      @(negedge ctx_clk);
      istart       = 1'b0;
      isample_tick = 1'b1;
      iseq_sel     = ~seq;
      iamp_shift   = ~sh;
      chk("busy_after_start", obusy, 1);
      chk("done_single_pulse", odone, 0);
      @(negedge ctx_clk);
      isample_tick = 1'b0;
      m_idx   = 0;
      m_lfsr  = seed;
      m_shift = int'(sh);
      n_valid = 0;
   endtask

   task automatic finish_burst();
      @(negedge ctx_clk);
      chk("done_pulse", odone, 1);
      chk("busy_fall_with_done", obusy, 0);
      chk("sample_zero_after_done", osample, 0);
      chk("burst_valid_count", n_valid, 4080);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rtx_rst = 1'b0; etx_en = 1'b1; isample_tick = 1'b0;
      istart = 1'b0; istop = 1'b0; iseq_sel = '0; iamp_shift = '0;
      repeat (3) @(negedge ctx_clk);
      chk("reset_sample", osample, 0);
      chk("reset_valid", osample_valid, 0);
      chk("reset_busy", obusy, 0);
      chk("reset_done", odone, 0);
      rtx_rst = 1'b1;
      @(negedge ctx_clk);

      // Full burst, sequence 0, unshifted, tick every 4 cycles.
      start_burst(4'd0, 2'd0, 8'h01, 1'b0);
      run_ticks(4080, 4);
      finish_burst();

      // Back-to-back start in the done cycle, with a coincident (ignored) tick.
      start_burst(4'd0, 2'd2, 8'h01, 1'b1);
      run_ticks(50, 2);
      istart = 1'b1; iseq_sel = 4'd1;
      @(negedge ctx_clk);
      istart = 1'b0;
      run_ticks(50, 2);
      istop = 1'b1; isample_tick = 1'b1;
      @(negedge ctx_clk);
      istop = 1'b0; isample_tick = 1'b0;
      chk("stop_sample", osample, 0);
      chk("stop_valid", osample_valid, 0);
      chk("stop_busy", obusy, 0);
      repeat (5) @(negedge ctx_clk);
      chk("stop_no_done", odone, 0);

      // Restart with seed 8'h5A, freeze for 50 cycles mid-burst.
      start_burst(4'd1, 2'd0, 8'h5A, 1'b0);
      run_ticks(40, 2);
      @(negedge ctx_clk);
      etx_en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         isample_tick = (i % 2 == 0);
         @(negedge ctx_clk);
         if (i == 25) chk("hold_mid_disable", osample, last_exp);
      end
      isample_tick = 1'b0;
      chk("hold_after_disable", osample, last_exp);
      chk("busy_held_disable", obusy, 1);
      etx_en = 1'b1;
      @(negedge ctx_clk);
      run_ticks(4040, 2);
      finish_burst();

      // Asynchronous reset off the clock edge in the middle of a burst.
      @(negedge ctx_clk);
      start_burst(4'd0, 2'd0, 8'h01, 1'b0);
      run_ticks(30, 2);
      #2 rtx_rst = 1'b0;
      #1;
      chk("async_rst_sample", osample, 0);
      chk("async_rst_valid", osample_valid, 0);
      chk("async_rst_busy", obusy, 0);
      chk("async_rst_done", odone, 0);
      @(negedge ctx_clk);
      rtx_rst = 1'b1;
      repeat (4) @(negedge ctx_clk);

      chk("total_done_pulses", n_done, 2);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
